// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types, opcodes and instruction-field helpers for cpu_controller
//
// Purpose: one place for the sequencer state encoding, the 3-bit opcode map,
//          the instruction field positions and small field-extraction helpers.
// Ports:   none (package).

package cpu_pkg;

  localparam int XLEN   = 32;
  localparam int NREG   = 8;
  localparam int REG_AW = 3;

  typedef enum logic [2:0] {
    START  = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_e;

  localparam logic [2:0] OP_NOOP = 3'b000;
  localparam logic [2:0] OP_HALT = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_SHL  = 3'b100;
  localparam logic [2:0] OP_SHR  = 3'b101;
  localparam logic [2:0] OP_ADDI = 3'b110;
  localparam logic [2:0] OP_SUBI = 3'b111;

  // Instruction layout: op | rd | rs1 | rs2 | imm
  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 29;
  localparam int RD_MSB  = 28;
  localparam int RD_LSB  = 26;
  localparam int RS1_MSB = 25;
  localparam int RS1_LSB = 23;
  localparam int RS2_MSB = 22;
  localparam int RS2_LSB = 20;
  localparam int IMM_MSB = 19;
  localparam int IMM_LSB = 0;
  localparam int IMM_W   = IMM_MSB - IMM_LSB + 1;

  function automatic logic [2:0] ir_op(input logic [XLEN-1:0] ir);
    return ir[OP_MSB:OP_LSB];
  endfunction

  function automatic logic [REG_AW-1:0] ir_rd(input logic [XLEN-1:0] ir);
    return ir[RD_MSB:RD_LSB];
  endfunction

  function automatic logic [REG_AW-1:0] ir_rs1(input logic [XLEN-1:0] ir);
    return ir[RS1_MSB:RS1_LSB];
  endfunction

  function automatic logic [REG_AW-1:0] ir_rs2(input logic [XLEN-1:0] ir);
    return ir[RS2_MSB:RS2_LSB];
  endfunction

  // Immediate is zero-extended, never sign-extended.
  function automatic logic [XLEN-1:0] ir_imm(input logic [XLEN-1:0] ir);
    return {{(XLEN-IMM_W){1'b0}}, ir[IMM_MSB:IMM_LSB]};
  endfunction

endpackage

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 8x32 register file, two read ports, debug read, one write port
//
// Purpose: architectural registers r0..r7; r0 always reads zero.
// Ports:
//   clk, rst            clock, asynchronous active-high reset (clears all registers)
//   rs1_addr_i/data_o   combinational read port A
//   rs2_addr_i/data_o   combinational read port B
//   dbg_addr_i/data_o   combinational debug read port
//   we_i, waddr_i,      synchronous write port; writes to r0 are dropped
//   wdata_i

module reg_file
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1_addr_i,
  output logic [XLEN-1:0]   rs1_data_o,
  input  logic [REG_AW-1:0] rs2_addr_i,
  output logic [XLEN-1:0]   rs2_data_o,
  input  logic [REG_AW-1:0] dbg_addr_i,
  output logic [XLEN-1:0]   dbg_data_o,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [XLEN-1:0]   wdata_i
);

  logic [XLEN-1:0] regs_q [NREG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // r0 is forced to zero on every read port.
  assign rs1_data_o = (rs1_addr_i == '0) ? '0 : regs_q[rs1_addr_i];
  assign rs2_data_o = (rs2_addr_i == '0) ? '0 : regs_q[rs2_addr_i];
  assign dbg_data_o = (dbg_addr_i == '0) ? '0 : regs_q[dbg_addr_i];

endmodule

// File: rtl/cpu_controller.sv
// rtl/cpu_controller.sv - multi-cycle fetch/decode/execute/writeback sequencer
//
// Purpose: fetches one instruction at a time, latches ALU operands, captures
//          the external ALU result and writes it back to the register file.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   imem_req/addr/ack/rdata  instruction fetch handshake (addr is always pc)
//   alu_a/alu_b/alu_op       operands and op to the external ALU
//   alu_result               combinational ALU result, captured in EXEC
//   retired                  one-cycle pulse per completed instruction
//   halted                   high while halted (exit only via reset)
//   dbg_sel/dbg_data         combinational debug register read

module cpu_controller
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [XLEN-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [XLEN-1:0]   imem_rdata,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  output logic [2:0]        alu_op,
  input  logic [XLEN-1:0]   alu_result,
  output logic              retired,
  output logic              halted,
  input  logic [REG_AW-1:0] dbg_sel,
  output logic [XLEN-1:0]   dbg_data
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] ir_q, ir_d;
  logic [XLEN-1:0] opa_q, opa_d;
  logic [XLEN-1:0] opb_q, opb_d;
  logic [XLEN-1:0] res_q, res_d;

  logic [2:0]      op;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            rf_we;

  assign op = ir_op(ir_q);

  reg_file u_reg_file (
    .clk        (clk),
    .rst        (rst),
    .rs1_addr_i (ir_rs1(ir_q)),
    .rs1_data_o (rs1_data),
    .rs2_addr_i (ir_rs2(ir_q)),
    .rs2_data_o (rs2_data),
    .dbg_addr_i (dbg_sel),
    .dbg_data_o (dbg_data),
    .we_i       (rf_we),
    .waddr_i    (ir_rd(ir_q)),
    .wdata_i    (res_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= START;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      START:   state_d = FETCH;
      FETCH:   if (imem_ack) state_d = DECODE;
      DECODE: begin
        if (op == OP_NOOP)      state_d = FETCH;
        else if (op == OP_HALT) state_d = HALT;
        else                    state_d = EXEC;
      end
      EXEC:    state_d = WB;
      WB:      state_d = FETCH;
      HALT:    state_d = HALT;
      default: state_d = START;
    endcase
  end

  // Datapath latches; pc wraps naturally at 2^32.
  always_comb begin
    pc_d  = pc_q;
    ir_d  = ir_q;
    opa_d = opa_q;
    opb_d = opb_q;
    res_d = res_q;
    unique case (state_q)
      FETCH: begin
        if (imem_ack) ir_d = imem_rdata;
      end
      DECODE: begin
        opa_d = rs1_data;
        opb_d = ((op == OP_ADDI) || (op == OP_SUBI)) ? ir_imm(ir_q) : rs2_data;
        if (op == OP_NOOP) pc_d = pc_q + 32'd4;
      end
      EXEC:    res_d = alu_result;
      WB:      pc_d  = pc_q + 32'd4;
      default: ;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    alu_op   = OP_NOOP;
    retired  = 1'b0;
    halted   = 1'b0;
    rf_we    = 1'b0;
    unique case (state_q)
      FETCH:   imem_req = 1'b1;
      DECODE:  retired  = (op == OP_NOOP);
      EXEC:    alu_op   = op;
      WB: begin
        rf_we   = 1'b1;
        retired = 1'b1;
      end
      HALT:    halted = 1'b1;
      default: ;
    endcase
  end

  assign imem_addr = pc_q;
  assign alu_a     = opa_q;
  assign alu_b     = opb_q;

endmodule

// File: tb/tb_cpu_controller.sv
// tb/tb_cpu_controller.sv - self-checking bench for cpu_controller

module tb_cpu_controller;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_op;
  logic        retired, halted;
  logic [2:0]  dbg_sel;
  logic [31:0] dbg_data;

  logic        rst2;
  logic        imem_req2;
  logic [31:0] imem_addr2;
  logic        imem_ack2;
  logic [31:0] imem_rdata2;
  logic [31:0] alu_a2, alu_b2, alu_result2;
  logic [2:0]  alu_op2;
  logic        retired2, halted2;
  logic [2:0]  dbg_sel2;
  logic [31:0] dbg_data2;

  assign imem_ack2   = 1'b1;
  assign imem_rdata2 = 32'h0;
  assign alu_result2 = 32'h0;
  assign dbg_sel2    = 3'd0;

  cpu_controller #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .alu_result(alu_result), .retired(retired), .halted(halted),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  cpu_controller #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
    .clk(clk), .rst(rst2), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ack(imem_ack2), .imem_rdata(imem_rdata2), .alu_a(alu_a2), .alu_b(alu_b2),
    .alu_op(alu_op2), .alu_result(alu_result2), .retired(retired2), .halted(halted2),
    .dbg_sel(dbg_sel2), .dbg_data(dbg_data2)
  );

  // Reference ALU sitting beside the controller.
  always_comb begin
    case (alu_op)
      OP_ADD, OP_ADDI: alu_result = alu_a + alu_b;
      OP_SUB, OP_SUBI: alu_result = alu_a - alu_b;
      OP_SHL:          alu_result = alu_a << alu_b;
      OP_SHR:          alu_result = alu_a >> alu_b;
      default:         alu_result = 32'h0;
    endcase
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [2:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic [2:0] rs2,
                                      input logic [19:0] imm);
    return {op, rd, rs1, rs2, imm};
  endfunction

  logic [31:0] mem   [64];
  int          waits [64];
  logic        noise;

  typedef struct {
    logic [31:0] pc;
    int          delta;
    bit          chk;
  } sb_item_t;

  sb_item_t sb_q [$];

  // Instruction memory responder and ISA model: pushes the expected retirement
  // (pc and spacing from the previous retirement) whenever a fetch is acked.
  initial begin
    int          cnt;
    logic [31:0] first_addr;
    logic [31:0] mpc;
    bit          mfirst;
    logic [31:0] w;
    sb_item_t    it;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    cnt = 0; first_addr = 32'h0; mpc = 32'h0; mfirst = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        imem_ack = 1'b0; imem_rdata = 32'h0;
        cnt = 0; mpc = 32'h0; mfirst = 1'b1;
      end else if (imem_req) begin
        if (cnt == 0) begin
          first_addr = imem_addr;
          check("fetch_addr", imem_addr, mpc);
        end else begin
          check("addr_stable", imem_addr, first_addr);
        end
        if (cnt < waits[imem_addr[7:2]]) begin
          imem_ack = 1'b0;
          cnt++;
        end else begin
          w = mem[imem_addr[7:2]];
          imem_ack   = 1'b1;
          imem_rdata = w;
          if (w[31:29] != OP_HALT) begin
            it.pc    = mpc;
            it.delta = ((w[31:29] == OP_NOOP) ? 2 : 4) + cnt;
            it.chk   = !mfirst;
            sb_q.push_back(it);
            mfirst = 1'b0;
            mpc    = mpc + 32'd4;
          end
          cnt = 0;
        end
      end else begin
        // Spurious acks carrying a HALT word must be ignored outside FETCH.
        imem_ack   = noise;
        imem_rdata = noise ? enc(OP_HALT, 3'd0, 3'd0, 3'd0, 20'h0) : 32'h0;
      end
    end
  end

  // Retirement monitor: pops the scoreboard on each retired pulse.
  initial begin
    int       cyc;
    int       last;
    sb_item_t it;
    cyc = 0; last = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        sb_q.delete();
      end else if (retired) begin
        check("sb_nonempty", {31'b0, sb_q.size() != 0}, 32'd1);
        if (sb_q.size() != 0) begin
          it = sb_q.pop_front();
          check("retire_pc", imem_addr, it.pc);
          if (it.chk) check("retire_gap", cyc - last, it.delta);
        end
        last = cyc;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) begin
      mem[i]   = 32'h0;
      waits[i] = 0;
    end
  endtask

  initial begin
    int          got;
    bit          found;
    logic [31:0] exp_rf [8];

    rst = 1'b1; rst2 = 1'b1; noise = 1'b0; dbg_sel = 3'd1;
    clear_mem();
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_req",     {31'b0, imem_req}, 32'd0);
    check("rst_addr",    imem_addr, 32'h0);
    check("rst_retired", {31'b0, retired}, 32'd0);
    check("rst_halted",  {31'b0, halted}, 32'd0);
    check("rst_aluop",   {29'b0, alu_op}, 32'd0);
    check("rst_alua",    alu_a, 32'h0);
    check("rst_alub",    alu_b, 32'h0);
    check("rst_dbg",     dbg_data, 32'h0);
    check("wrap_rst_addr", imem_addr2, 32'hFFFF_FFFC);

    // RESET_PC = FFFF_FFFC running NOOPs: pc wraps to 0 on the second fetch.
    #1 rst2 = 1'b0;
    got = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (imem_req2) begin
        if (got == 0) begin
          check("wrap_first_cycle", n, 1);
          check("wrap_fetch0", imem_addr2, 32'hFFFF_FFFC);
        end else if (got == 1) begin
          check("wrap_fetch1", imem_addr2, 32'h0);
        end
        got++;
      end
    end
    check("wrap_fetches", {31'b0, got >= 2}, 32'd1);
    rst2 = 1'b1;

    // Run 1: ALU ops, r0 discard, shifts >= 32, wait states, spurious acks.
    mem[0]  = enc(OP_ADDI, 3'd1, 3'd0, 3'd0, 20'd5);
    mem[1]  = enc(OP_ADD,  3'd2, 3'd1, 3'd1, 20'h00077);
    mem[2]  = enc(OP_SUBI, 3'd3, 3'd0, 3'd0, 20'd1);
    mem[3]  = enc(OP_ADDI, 3'd0, 3'd0, 3'd0, 20'd7);
    mem[4]  = enc(OP_SHL,  3'd4, 3'd1, 3'd2, 20'h00003);
    mem[5]  = enc(OP_SHR,  3'd6, 3'd4, 3'd2, 20'h0);
    mem[6]  = enc(OP_ADDI, 3'd2, 3'd0, 3'd0, 20'd40);
    mem[7]  = enc(OP_SHL,  3'd5, 3'd1, 3'd2, 20'h0);
    mem[8]  = enc(OP_SUB,  3'd7, 3'd2, 3'd1, 20'h0);
    mem[9]  = enc(OP_NOOP, 3'd0, 3'd0, 3'd0, 20'h0);
    mem[10] = enc(OP_ADDI, 3'd6, 3'd6, 3'd0, 20'hFFFFF);
    mem[11] = enc(OP_HALT, 3'd0, 3'd0, 3'd0, 20'h0);
    waits[5] = 3;
    noise = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 400 && !halted; i++) @(negedge clk);
    check("run1_halted", {31'b0, halted}, 32'd1);
    repeat (25) begin
      @(negedge clk);
      check("run1_halt_req",  {31'b0, imem_req}, 32'd0);
      check("run1_halt_pc",   imem_addr, 32'd44);
      check("run1_halt_hold", {31'b0, halted}, 32'd1);
    end
    check("run1_sb_drained", sb_q.size(), 32'd0);
    exp_rf[0] = 32'h0;         exp_rf[1] = 32'h5;
    exp_rf[2] = 32'd40;        exp_rf[3] = 32'hFFFF_FFFF;
    exp_rf[4] = 32'h0000_1400; exp_rf[5] = 32'h0;
    exp_rf[6] = 32'h0010_0004; exp_rf[7] = 32'd35;
    for (int r = 0; r < 8; r++) begin
      dbg_sel = r[2:0];
      #1 check($sformatf("run1_r%0d", r), dbg_data, exp_rf[r]);
    end

    // Run 2: exact cycle timing, HALT at address 8.
    @(negedge clk);
    #1 rst = 1'b1;
    clear_mem();
    noise  = 1'b0;
    mem[0] = enc(OP_ADDI, 3'd1, 3'd0, 3'd0, 20'd5);
    mem[1] = enc(OP_ADD,  3'd2, 3'd1, 3'd1, 20'h0);
    mem[2] = enc(OP_HALT, 3'd0, 3'd0, 3'd0, 20'h0);
    @(negedge clk);
    #1 rst = 1'b0;
    check("run2_start_req", {31'b0, imem_req}, 32'd0);
    for (int n = 1; n <= 11; n++) begin
      @(negedge clk);
      check("run2_req", {31'b0, imem_req}, {31'b0, (n % 4) == 1});
      if ((n % 4) == 1) check("run2_addr", imem_addr, n - 1);
      check("run2_halted", {31'b0, halted}, {31'b0, n >= 11});
    end
    repeat (22) begin
      @(negedge clk);
      check("run2_halt_req", {31'b0, imem_req}, 32'd0);
      check("run2_halt_pc",  imem_addr, 32'd8);
    end
    dbg_sel = 3'd1;
    #1 check("run2_r1", dbg_data, 32'd5);
    dbg_sel = 3'd2;
    #1 check("run2_r2", dbg_data, 32'h0000_000A);

    // Run 3: reset during EXEC aborts the instruction.
    @(negedge clk);
    #1 rst = 1'b1;
    clear_mem();
    mem[0] = enc(OP_ADDI, 3'd1, 3'd0, 3'd0, 20'd9);
    @(negedge clk);
    #1 rst = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (alu_op == OP_ADDI) found = 1'b1;
    end
    check("run3_exec_seen", {31'b0, found}, 32'd1);
    check("run3_exec_alub", alu_b, 32'd9);
    #1 rst = 1'b1;
    #1;
    check("run3_req",     {31'b0, imem_req}, 32'd0);
    check("run3_retired", {31'b0, retired}, 32'd0);
    check("run3_halted",  {31'b0, halted}, 32'd0);
    check("run3_aluop",   {29'b0, alu_op}, 32'd0);
    check("run3_alua",    alu_a, 32'h0);
    check("run3_alub",    alu_b, 32'h0);
    check("run3_addr",    imem_addr, 32'h0);
    dbg_sel = 3'd1;
    #1 check("run3_r1", dbg_data, 32'h0);
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("run3_refetch_req",  {31'b0, imem_req}, 32'd1);
    check("run3_refetch_addr", imem_addr, 32'h0);
    #1 rst = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_controller.md
# cpu_controller

Multi-cycle fetch/decode/execute/writeback sequencer for the TopCPU datapath, sitting directly upstream of the ALU.
- Fetches 32-bit instructions over a simple request/acknowledge port.
- Decodes them into the ALU's 3-bit operation code and A/B operands.
- Captures the ALU result and writes it back into an internal 8×32 register file.
- Instructions execute one at a time; there is no pipelining.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request; high only in FETCH.
- imem_addr  out  32  byte address of the fetch, always equal to pc.
- imem_ack  in  1  memory acknowledge; sampled only in FETCH.
- imem_rdata  in  32  instruction word; valid in the cycle imem_ack is high.
- alu_a  out  32  ALU operand A (latched rs1 value).
- alu_b  out  32  ALU operand B (latched rs2 value or zero-extended imm).
- alu_op  out  3  ALU operation; equals ir[31:29] in EXEC and 3'b000 in every other state.
- alu_result  in  32  combinational ALU result; sampled at the end of EXEC.
- retired  out  1  one-cycle pulse per completed instruction.
- halted  out  1  high while in HALT.
- dbg_sel  in  3  debug register select.
- dbg_data  out  32  combinational read of register dbg_sel.

## Operation
Instruction format:
- op = ir[31:29], rd = ir[28:26], rs1 = ir[25:23], rs2 = ir[22:20], imm = ir[19:0], zero-extended to 32 bits.

Opcodes:
- 000 NOOP
- 001 HALT
- 010 ADD
- 011 SUB
- 100 SHL
- 101 SHR
- 110 ADDI
- 111 SUBI
- For ADDI/SUBI, B is the zero-extended imm. For all other ALU ops, B = rf[rs2]. Shift amounts use all 32 bits of B, so a shift of 32 or more yields 0.

Register file:
- r0 always reads 0; writes to r0 are discarded.
- r1–r7 reset to 0.

States:
- START: no request. Next state is FETCH.
- FETCH: imem_req=1, imem_addr=pc.
  - If imem_ack=0, stay in FETCH.
  - If imem_ack=1, ir <= imem_rdata and go to DECODE.
- DECODE: opA <= rf[rs1]; opB <= imm or rf[rs2].
  - NOOP: pc <= pc+4, retired=1, go to FETCH.
  - HALT: go to HALT; pc is not advanced and retired is not pulsed.
  - Any other op: go to EXEC.
- EXEC: alu_a=opA, alu_b=opB, alu_op=op. res <= alu_result. Go to WB.
- WB: rf[rd] <= res; pc <= pc+4; retired=1. Go to FETCH.
- HALT: halted=1 and imem_req=0. The block leaves HALT only on reset.

Rules:
- pc increments modulo 2^32, so 32'hFFFF_FFFC + 4 = 0.
- imem_ack outside FETCH is ignored, and imem_rdata is not sampled.
- Register reads in DECODE see every earlier instruction's writeback, because instructions do not overlap.
- Reset mid-instruction aborts the instruction: no writeback, no retired pulse, pc = RESET_PC.

## Timing
Reset values (asserted asynchronously):
- State START, pc = RESET_PC, ir/opA/opB/res = 0, all registers 0.
- imem_req=0, retired=0, halted=0, alu_op=000, alu_a=0, alu_b=0.
- imem_addr = RESET_PC.

Cycle-level behaviour:
- First imem_req is in the second cycle after reset is released (START occupies one cycle).
- ALU instruction: 4 cycles from FETCH entry to the retired pulse with zero-wait ack (FETCH, DECODE, EXEC, WB), plus one cycle per ack wait.
- NOOP takes 2 cycles.
- rf write and pc update take effect on the WB clock edge. A following instruction's DECODE is at least 2 cycles later.
- imem_addr is stable from FETCH entry until ack.
- dbg_data is combinational and reflects a write in the cycle after the WB edge.

## Structure
Package cpu_pkg:
- State enum: START, FETCH, DECODE, EXEC, WB, HALT.
- Opcode constants: OP_NOOP, OP_HALT, OP_ADD, OP_SUB, OP_SHL, OP_SHR, OP_ADDI, OP_SUBI.
- Instruction field bit-position constants.
- XLEN=32, NREG=8.

Sub-module reg_file:
- 8×32 storage.
- Two combinational read ports plus a debug read port.
- One synchronous write port with enable.
- r0 hardwired to zero.
- Asynchronous reset to 0.

The controller FSM, pc, ir and operand latches live in cpu_controller. The bench instantiates the ALU alongside it.

## Test plan
- ADDI r1,r0,5 then ADD r2,r1,r1, zero-wait ack: r1=5, r2=10 (0x0000000A). retired pulses 4 cycles apart. imem_addr sequence 0, 4, 8.
- SUBI r3,r0,1: r3=32'hFFFF_FFFF. ADDI r0,r0,7: dbg r0 stays 0.
- r1=5, r2=10, SHL r4,r1,r2: r4=32'h0000_1400. With r2 set to 40 via ADDI, SHL r5,r1,r2: r5=0. SHR r6,r4,r2 (r2=10): r6=5.
- imem_ack withheld 3 cycles: imem_req stays high and imem_addr stays constant. DECODE is entered only after the ack cycle. An ack pulse injected in EXEC has no effect.
- HALT at address 8: halted=1 from the next cycle, imem_req=0 for more than 20 cycles, pc stays 8, no retired pulse.
- rst asserted during EXEC of ADDI r1,r0,9: all outputs at reset values immediately, r1=0, first imem_addr after release = RESET_PC. RESET_PC=32'hFFFF_FFFC with NOOP: second fetch at address 0.
